// File: rtl/generic_output_ctrl_if.sv
// generic_output_ctrl_if: register port and output bus of generic_output_ctrl
interface generic_output_ctrl_if #(parameter int OW = 1);
  logic we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [OW-1:0] o;
  modport master(output we, addr, wdata, input rdata, o);
  modport slave(input we, addr, wdata, output rdata, o);
endinterface

// File: rtl/generic_output_ctrl.sv
// generic_output_ctrl: per-channel steady/blink/one-shot output controller
module generic_output_ctrl #(
  parameter int OW = 1,
  parameter logic DS = 1'b0,
  parameter int PW = 16,
  parameter int PDIV = 50000
) (
  input logic clk,
  input logic rst,
  generic_output_ctrl_if.slave bus
);
  logic [PW-1:0] pcnt;
  logic tick;
  logic [OW-1:0] phase;
  logic [7:0] rd [8];
  assign tick = pcnt == PW'(PDIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) pcnt <= '0;
    else pcnt <= tick ? '0 : pcnt + PW'(1);
  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < OW) begin : g_on
      logic [1:0] mode;
      logic [5:0] per, cnt;
      logic ph, wr;
      assign wr = bus.we && bus.addr == 3'(i);
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          mode <= '0;
          per <= '0;
          cnt <= '0;
          ph <= 1'b0;
        end else if (wr) begin
          mode <= bus.wdata[7:6];
          per <= bus.wdata[5:0];
          cnt <= '0;
          ph <= |bus.wdata[7:6];
        end else if (tick && mode[1]) begin
          cnt <= cnt == per ? '0 : cnt + 6'd1;
          if (cnt == per) begin
            ph <= ~ph & ~mode[0];
            mode <= mode[0] ? 2'd0 : mode;
          end
        end
      assign phase[i] = ph;
      assign rd[i] = {mode, per};
    end else begin : g_off
      assign rd[i] = '0;
    end
  end
  assign bus.rdata = rd[bus.addr];
  assign bus.o = phase ^ {OW{DS}};
endmodule

// File: tb/tb_generic_output_ctrl.sv
// tb_generic_output_ctrl: randomized and directed checks against a tick-arithmetic model
module tb_generic_output_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int ecount = 0;
  int wedge [4];
  logic [1:0] wmode [4];
  logic [5:0] wper [4];
  generic_output_ctrl_if #(.OW(4)) bus();
  generic_output_ctrl #(.OW(4), .DS(1'b0), .PDIV(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst)
    if (rst) ecount <= 0;
    else ecount <= ecount + 1;
  function automatic int since(int c);
    return ecount / 4 - wedge[c] / 4;
  endfunction
  function automatic logic exp_ph(int c);
    int n = since(c);
    int p = int'(wper[c]) + 1;
    case (wmode[c])
      2'd0: return 1'b0;
      2'd1: return 1'b1;
      2'd2: return (n / p) % 2 == 0;
      default: return n < p;
    endcase
  endfunction
  function automatic logic [3:0] exp_o();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = exp_ph(c);
    return r;
  endfunction
  function automatic logic [7:0] exp_rd(int a);
    if (a >= 4) return 8'h00;
    if (wmode[a] == 2'd3 && since(a) >= int'(wper[a]) + 1) return {2'b00, wper[a]};
    return {wmode[a], wper[a]};
  endfunction
  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      wmode[c] = 2'd0;
      wper[c] = 6'd0;
      wedge[c] = 0;
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.we = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    @(posedge clk);
    #1 bus.we = 1'b0;
    if (a < 3'd4) begin
      wmode[a[1:0]] = d[7:6];
      wper[a[1:0]] = d[5:0];
      wedge[a[1:0]] = ecount;
    end
  endtask
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o !== 4'b0000) begin n_fail++; $display("FAIL reset_o: got %b expected 0000", bus.o); end
    for (int a = 0; a < 8; a++) begin
      bus.addr = 3'(a);
      #1;
      n_checks++;
      if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 00", a, bus.rdata); end
    end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      n_checks++;
      if (bus.o !== 4'b0000 || dut.tick !== (ecount % 4 == 3)) begin
        n_fail++;
        $display("FAIL reset_release: o=%b tick=%b expected o=0000 tick=%b at clk %0d", bus.o, dut.tick, ecount % 4 == 3, ecount);
      end
    end
  endtask
  task automatic test_steady();
    wr(3'd2, 8'h40);
    @(negedge clk);
    n_checks++;
    if (bus.o !== 4'b0100) begin n_fail++; $display("FAIL steady_o: got %b expected 0100", bus.o); end
    bus.addr = 3'd2;
    #1;
    n_checks++;
    if (bus.rdata !== 8'h40) begin n_fail++; $display("FAIL steady_rdata: got %h expected 40", bus.rdata); end
    repeat (100) begin
      @(negedge clk);
      n_checks++;
      if (bus.o !== 4'b0100) begin n_fail++; $display("FAIL steady_hold: got %b expected 0100", bus.o); end
    end
    wr(3'd2, 8'h00);
    @(negedge clk);
    n_checks++;
    if (bus.o[2] !== 1'b0) begin n_fail++; $display("FAIL steady_off: got %b expected 0", bus.o[2]); end
  endtask
  task automatic test_blink();
    logic prev;
    int tlast = -1;
    int ntog = 0;
    wr(3'd0, 8'h81);
    @(negedge clk);
    n_checks++;
    if (bus.o[0] !== 1'b1) begin n_fail++; $display("FAIL blink_start: got %b expected 1", bus.o[0]); end
    prev = bus.o[0];
    repeat (88) begin
      @(negedge clk);
      n_checks++;
      if (bus.o !== exp_o()) begin n_fail++; $display("FAIL blink_o: got %b expected %b at clk %0d", bus.o, exp_o(), ecount); end
      if (bus.o[0] !== prev) begin
        if (tlast >= 0) begin
          n_checks++;
          if (ecount - tlast != 8) begin n_fail++; $display("FAIL blink_period: got %0d clocks expected 8", ecount - tlast); end
        end
        tlast = ecount;
        ntog++;
        prev = bus.o[0];
      end
    end
    n_checks++;
    if (ntog < 10) begin n_fail++; $display("FAIL blink_toggles: got %0d expected at least 10", ntog); end
  endtask
  task automatic test_oneshot();
    wr(3'd1, 8'hC2);
    repeat (16) begin
      @(negedge clk);
      n_checks++;
      if (bus.o !== exp_o()) begin n_fail++; $display("FAIL oneshot_o: got %b expected %b at clk %0d", bus.o, exp_o(), ecount); end
    end
    bus.addr = 3'd1;
    #1;
    n_checks++;
    if (bus.rdata !== 8'h02 || bus.o[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_end: rdata=%h o1=%b expected rdata=02 o1=0", bus.rdata, bus.o[1]);
    end
  endtask
  task automatic test_collision();
    logic o3;
    wr(3'd0, 8'h82);
    wr(3'd3, 8'h80);
    repeat (6) @(negedge clk);
    while (ecount % 4 != 3) @(negedge clk);
    o3 = bus.o[3];
    bus.we = 1'b1;
    bus.addr = 3'd0;
    bus.wdata = 8'h81;
    @(posedge clk);
    #1 bus.we = 1'b0;
    wmode[0] = 2'd2;
    wper[0] = 6'd1;
    wedge[0] = ecount;
    @(negedge clk);
    n_checks++;
    if (bus.o[0] !== 1'b1 || bus.o[3] !== ~o3) begin
      n_fail++;
      $display("FAIL collision_edge: o0=%b o3=%b expected o0=1 o3=%b", bus.o[0], bus.o[3], ~o3);
    end
    repeat (24) begin
      @(negedge clk);
      n_checks++;
      if (bus.o !== exp_o()) begin n_fail++; $display("FAIL collision_o: got %b expected %b at clk %0d", bus.o, exp_o(), ecount); end
    end
  endtask
  task automatic test_invalid();
    wr(3'd5, 8'h40);
    @(negedge clk);
    n_checks++;
    if (bus.o !== exp_o()) begin n_fail++; $display("FAIL invalid_o: got %b expected %b", bus.o, exp_o()); end
    bus.addr = 3'd5;
    #1;
    n_checks++;
    if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL invalid_rdata: got %h expected 00", bus.rdata); end
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      bus.addr = 3'(a);
      #1;
      n_checks++;
      if (bus.rdata !== exp_rd(a)) begin n_fail++; $display("FAIL invalid_regs[%0d]: got %h expected %h", a, bus.rdata, exp_rd(a)); end
    end
  endtask
  task automatic test_random();
    int a;
    repeat (400) begin
      if ($urandom_range(0, 4) == 0)
        wr(3'($urandom_range(0, 7)), {2'($urandom_range(0, 3)), 6'($urandom_range(0, 3))});
      @(negedge clk);
      n_checks++;
      if (bus.o !== exp_o()) begin n_fail++; $display("FAIL random_o: got %b expected %b at clk %0d", bus.o, exp_o(), ecount); end
      a = $urandom_range(0, 7);
      bus.addr = 3'(a);
      #1;
      n_checks++;
      if (bus.rdata !== exp_rd(a)) begin n_fail++; $display("FAIL random_rdata[%0d]: got %h expected %h", a, bus.rdata, exp_rd(a)); end
    end
  endtask
  task automatic test_async_reset();
    wr(3'd0, 8'h81);
    wr(3'd3, 8'hC5);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o !== 4'b0000) begin n_fail++; $display("FAIL async_reset_o: got %b expected 0000", bus.o); end
    for (int a = 0; a < 8; a++) begin
      bus.addr = 3'(a);
      #1;
      n_checks++;
      if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL async_reset_rdata[%0d]: got %h expected 00", a, bus.rdata); end
    end
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      n_checks++;
      if (bus.o !== 4'b0000 || dut.tick !== (ecount % 4 == 3)) begin
        n_fail++;
        $display("FAIL async_release: o=%b tick=%b expected o=0000 tick=%b at clk %0d", bus.o, dut.tick, ecount % 4 == 3, ecount);
      end
    end
  endtask
  initial begin
    bus.we = 1'b0;
    bus.addr = 3'd0;
    bus.wdata = 8'h00;
    model_clear();
    test_reset();
    test_steady();
    test_blink();
    test_oneshot();
    test_collision();
    test_invalid();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/generic_output_ctrl.md
# generic_output_ctrl

Synthesizable per-channel output controller that drives LED-type outputs: the stage directly upstream of the bench output monitor. It holds a mode and period register per channel, written over a simple register port, and generates steady, blinking or one-shot levels from a shared prescaler tick. Each output rests at the off level `DS` from reset and whenever its channel is off.

## Interface
Parameters:
- `OW`, 1: number of output channels, 1..8.
- `DS`, 1'b0: off (inactive) level of every output; the active level is `~DS`.
- `PW`, 16: prescaler counter width.
- `PDIV`, 50000: prescaler divisor; one tick every `PDIV` clocks, 2..2^PW.

Ports:
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `we`  in  1  write strobe, single-cycle, sampled on `clk`.
- `addr`  in  3  channel select.
- `wdata`  in  8  `[7:6]` mode, `[5:0]` period `P`.
- `rdata`  out  8  combinational readback `{mode, P}` of channel `addr`; 0 when `addr >= OW`.
- `o`  out  OW  channel outputs.

## Operation
- Prescaler `pcnt` (PW bits) free-runs 0..PDIV-1 and wraps. `tick` is high in the cycle where `pcnt == PDIV-1`. Writes never reset the prescaler.
- Per-channel state: `mode[1:0]`, `per[5:0]`, `cnt[5:0]`, `phase` (1 = active).
- Modes:
  - 0 OFF: phase 0.
  - 1 ON: phase 1.
  - 2 BLINK: on each tick, if `cnt == per` then `cnt <= 0` and `phase` toggles, else `cnt++`. Each phase lasts `P+1` ticks.
  - 3 ONESHOT: phase 1 until the tick where `cnt == per`. On that tick `mode <= 0`, `phase <= 0` and `cnt <= 0`. `rdata` then reads mode 0.
- A write with `addr < OW` loads `mode` and `per` and clears `cnt`. It sets `phase` to 1 for modes 1, 2 and 3, and to 0 for mode 0. This restarts any blink or one-shot in progress.
- A write with `addr >= OW` is ignored and has no effect on any state.
- Each channel is independent. A write touches only the addressed channel.
- `o[i] = phase[i] ? ~DS : DS`, driven directly from the `phase` register with no added logic state.

## Timing
- Reset (asynchronous, any time, including mid-blink or mid-one-shot):
  - `pcnt`, `mode`, `per`, `cnt` and `phase` all go to 0.
  - `o = {OW{DS}}` immediately.
  - `rdata` reads 0 for every channel.
- Write latency: `o` shows the new mode after the clock edge that samples `we`. Output latency is 1 clock.
- Tick latency: a phase toggle is visible on `o` after the edge where `tick` was high.
- First blink phase or one-shot after a write ends at the (P+1)-th tick following the write edge. That is between `P*PDIV+1` and `(P+1)*PDIV` clocks, depending on the prescaler position. Every later phase is exactly `(P+1)*PDIV` clocks.
- Write and tick in the same cycle on the same channel: the write wins and the tick is ignored for that channel. Other channels still process the tick.
- `P = 0`: blink toggles on every tick; a one-shot lasts exactly 1 tick.
- `cnt` never exceeds `per`, so there is no wrap-around beyond 6 bits.
- Modes 0 and 1 ignore ticks, and `cnt` holds at 0.

## Test plan
Bench parameters: `OW=4`, `DS=1'b0`, `PDIV=4`.
- Reset: assert `rst` asynchronously mid-blink -> `o=4'b0000` immediately and all `rdata=0`. Release `rst` -> `o` stays 0 and the first tick occurs 4 clocks later.
- Steady on: write ch2 `wdata=8'h40` -> `o=4'b0100` one edge later, `rdata=8'h40` at `addr=2`, unchanged for 100 clocks. Then write ch2 `8'h00` -> `o[2]=0` next edge.
- Blink: write ch0 `8'h81` (P=1) -> `o[0]=1` at once and toggles at the 2nd tick after the write. Thereafter the period is 8 clocks on and 8 clocks off, checked over 5 periods.
- One-shot: write ch1 `8'hC2` (P=2) -> `o[1]=1` until the 3rd tick, then `o[1]=0`. `rdata` at `addr=1` becomes `8'h02` and `o[1]` stays 0.
- Collision: issue the write to ch0 in exactly the cycle `tick=1` while ch3 is blinking -> ch0 `cnt=0`, `phase=1`, and ch3 still toggles on that tick.
- Invalid address: write `addr=5` with `8'h40` -> no change on `o`, and `rdata` at `addr=5` is 0.
